// File: rtl/pc_gen_if.sv
// Fetch-PC bundle between redirect logic, pc_gen and the fetch port.
// slave is the pc_gen side; master is the driving side.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic [2:0]      io_pc_sel;
  logic [XLEN-1:0] io_pc_br;
  logic [XLEN-1:0] io_pc_jmp;
  logic [XLEN-1:0] io_pc_jalr;
  logic [XLEN-1:0] io_pc_excp;
  logic            io_stall;
  logic            io_pc_ready;
  logic [XLEN-1:0] io_pc_out;
  logic            io_pc_valid;
  logic            io_pc_misalign;
  logic            io_pc_pending;

  modport slave (
    input  io_pc_sel, io_pc_br, io_pc_jmp,
    input  io_pc_jalr, io_pc_excp,
    input  io_stall, io_pc_ready,
    output io_pc_out, io_pc_valid,
    output io_pc_misalign, io_pc_pending
  );

  modport master (
    output io_pc_sel, io_pc_br, io_pc_jmp,
    output io_pc_jalr, io_pc_excp,
    output io_stall, io_pc_ready,
    input  io_pc_out, io_pc_valid,
    input  io_pc_misalign, io_pc_pending
  );
endinterface

// File: rtl/pc_gen.sv
// Registered fetch PC with stall-time redirect buffer,
// fetch handshake and redirect-target alignment check.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0200,
  parameter int              IALIGN       = 4
) (
  input  logic      clk,
  input  logic      reset,
  pc_gen_if.slave   bus
);
  localparam int LSB = $clog2(IALIGN);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    PEND
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] jalr_t;
  logic            is_redir;
  logic            is_excp;
  logic            mis;
  logic            ok_redir;
  logic            fire;

  assign jalr_t = {bus.io_pc_jalr[XLEN-1:1], 1'b0};

  // Decode the source select and pick the redirect target.
  always_comb begin
    tgt      = bus.io_pc_br;
    is_redir = 1'b0;
    is_excp  = 1'b0;
    unique case (bus.io_pc_sel)
      3'd1: begin
        tgt      = bus.io_pc_br;
        is_redir = 1'b1;
      end
      3'd2: begin
        tgt      = bus.io_pc_jmp;
        is_redir = 1'b1;
      end
      3'd3: begin
        tgt      = jalr_t;
        is_redir = 1'b1;
      end
      3'd4: is_excp = 1'b1;
      default: ;
    endcase
  end

  assign mis = is_redir && (state_q != BOOT)
            && (tgt[LSB-1:0] != '0);
  assign ok_redir = is_redir && !mis;
  assign fire = bus.io_pc_valid && bus.io_pc_ready;

  assign bus.io_pc_out      = pc_q;
  assign bus.io_pc_valid    = (state_q != BOOT);
  assign bus.io_pc_pending  = (state_q == PEND);
  assign bus.io_pc_misalign = mis;

  // Next PC, pending target and state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (is_excp) begin
          pc_d = bus.io_pc_excp;
        end else if (bus.io_stall) begin
          if (ok_redir) begin
            pend_d  = tgt;
            state_d = PEND;
          end
        end else if (ok_redir) begin
          pc_d = tgt;
        end else if (!is_redir && fire) begin
          pc_d = pc_q + XLEN'(IALIGN);
        end
      end
      PEND: begin
        if (is_excp) begin
          pc_d    = bus.io_pc_excp;
          pend_d  = '0;
          state_d = RUN;
        end else if (bus.io_stall) begin
          if (ok_redir) pend_d = tgt;
        end else begin
          pc_d    = ok_redir ? tgt : pend_q;
          pend_d  = '0;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State, PC and pending registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen.
// Driver queues expectations; monitor compares.
module tb_pc_gen;
  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        pend;
    logic        mis;
  } exp_t;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  exp_t sb[$];

  pc_gen_if #(.XLEN(32)) bus();

  pc_gen #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0200),
    .IALIGN(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  // Set inputs now; expected outputs apply after the next edge.
  task automatic cyc(input logic [2:0] sel,
                     input logic stall,
                     input logic ready,
                     input logic [31:0] tgt,
                     input logic [31:0] epc,
                     input logic evld,
                     input logic epend,
                     input logic emis);
    exp_t e;
    bus.io_pc_sel   = sel;
    bus.io_stall    = stall;
    bus.io_pc_ready = ready;
    bus.io_pc_br    = tgt;
    bus.io_pc_jmp   = tgt;
    bus.io_pc_jalr  = tgt;
    bus.io_pc_excp  = tgt;
    e.pc    = epc;
    e.valid = evld;
    e.pend  = epend;
    e.mis   = emis;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: misalign is sampled mid-cycle, registered
  // outputs just after the edge.
  initial begin
    logic mis_s;
    exp_t e;
    forever begin
      @(negedge clk);
      #1 mis_s = bus.io_pc_misalign;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("misalign", 32'(mis_s), 32'(e.mis));
        chk("pc", bus.io_pc_out, e.pc);
        chk("valid", 32'(bus.io_pc_valid), 32'(e.valid));
        chk("pending", 32'(bus.io_pc_pending), 32'(e.pend));
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b0;
    bus.io_pc_sel   = 3'd0;
    bus.io_stall    = 1'b0;
    bus.io_pc_ready = 1'b1;
    bus.io_pc_br    = '0;
    bus.io_pc_jmp   = '0;
    bus.io_pc_jalr  = '0;
    bus.io_pc_excp  = '0;

    #12;
    chk("rst_pc", bus.io_pc_out, 32'h200);
    chk("rst_valid", 32'(bus.io_pc_valid), 32'd0);
    chk("rst_pend", 32'(bus.io_pc_pending), 32'd0);
    chk("rst_mis", 32'(bus.io_pc_misalign), 32'd0);

    @(negedge clk);
    reset = 1'b1;
    cyc(0, 0, 1, 0, 32'h200, 1, 0, 0);
    cyc(0, 0, 1, 0, 32'h204, 1, 0, 0);
    cyc(0, 0, 1, 0, 32'h208, 1, 0, 0);
    cyc(0, 0, 0, 0, 32'h208, 1, 0, 0);
    cyc(0, 0, 0, 0, 32'h208, 1, 0, 0);
    cyc(0, 0, 0, 0, 32'h208, 1, 0, 0);
    cyc(1, 0, 0, 32'h1000, 32'h1000, 1, 0, 0);
    cyc(0, 0, 1, 0, 32'h1004, 1, 0, 0);
    cyc(3, 0, 1, 32'h2003, 32'h1004, 1, 0, 1);
    cyc(3, 0, 1, 32'h3001, 32'h3000, 1, 0, 0);
    cyc(2, 1, 1, 32'h4002, 32'h3000, 1, 0, 1);
    cyc(2, 1, 1, 32'h4000, 32'h3000, 1, 1, 0);
    cyc(1, 1, 1, 32'h5000, 32'h3000, 1, 1, 0);
    cyc(0, 1, 1, 0, 32'h3000, 1, 1, 0);
    cyc(0, 0, 1, 0, 32'h5000, 1, 0, 0);
    cyc(2, 1, 1, 32'h4000, 32'h5000, 1, 1, 0);
    cyc(4, 1, 1, 32'h80, 32'h80, 1, 0, 0);
    cyc(1, 1, 1, 32'h6000, 32'h80, 1, 1, 0);
    cyc(2, 0, 1, 32'h7000, 32'h7000, 1, 0, 0);
    cyc(1, 1, 1, 32'h6000, 32'h7000, 1, 1, 0);
    cyc(3, 0, 1, 32'h6006, 32'h6000, 1, 0, 1);
    cyc(2, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0);
    cyc(0, 0, 1, 0, 32'h0, 1, 0, 0);
    cyc(0, 0, 1, 0, 32'h4, 1, 0, 0);
    cyc(5, 0, 1, 32'h9000, 32'h8, 1, 0, 0);
    cyc(4, 1, 1, 32'h100, 32'h100, 1, 0, 0);
    cyc(2, 1, 1, 32'h4000, 32'h100, 1, 1, 0);
    drain();

    bus.io_pc_sel = 3'd0;
    bus.io_stall  = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_pc", bus.io_pc_out, 32'h200);
    chk("mid_rst_pend", 32'(bus.io_pc_pending), 32'd0);
    chk("mid_rst_valid", 32'(bus.io_pc_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 0, 1, 0, 32'h200, 1, 0, 0);
    cyc(0, 0, 1, 0, 32'h204, 1, 0, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
